// File: rtl/priority_load_reg.sv
// priority_load_reg: multi-writer datapath register with fixed-priority load,
// increment with carry pulse for chaining, and debug conflict tracking.
// Optional feature: define PRIORITY_LOAD_REG_SHADOW_EN to add a shadow
// register with save/restore ports (interrupt PC save/restore).
module priority_load_reg #(
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_SRC   = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*WIDTH-1:0]   i_data_in,
    input  logic [NUM_SRC-1:0]         i_load,
    input  logic                       i_inc,
    input  logic                       i_clr_conflict,
`ifdef PRIORITY_LOAD_REG_SHADOW_EN
    input  logic                       i_save,
    input  logic                       i_restore,
    output logic [WIDTH-1:0]           o_shadow_out,
`endif
    output logic [WIDTH-1:0]           o_data_out,
    output logic                       o_carry_out,
    output logic                       o_conflict,
    output logic [CNT_W-1:0]           o_conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]  r_data;
    logic              r_carry;
    logic              r_conflict;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic [WIDTH-1:0]  w_data_next;
    logic              w_carry_next;
    logic              w_conflict_next;
    logic [CNT_W-1:0]  w_conflict_cnt_next;

    logic              w_any_load;
    logic              w_multi_load;
    logic              w_event;
    logic              w_restore;
    logic [WIDTH-1:0]  w_shadow;

    // Priority chain: each stage passes its own source if requested,
    // otherwise whatever the lower-priority stages selected. Stage 0 wins.
    logic [WIDTH-1:0]  w_sel_chain [NUM_SRC+1];

    assign w_sel_chain[NUM_SRC] = '0;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
            assign w_sel_chain[gi] = i_load[gi] ? i_data_in[gi*WIDTH +: WIDTH]
                                                : w_sel_chain[gi+1];
        end
    endgenerate

    assign w_any_load   = |i_load;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi_load = |(i_load & (i_load - NUM_SRC'(1)));
    assign w_event      = w_multi_load | (w_any_load & i_inc);

`ifdef PRIORITY_LOAD_REG_SHADOW_EN
    logic [WIDTH-1:0] r_shadow;

    assign w_restore    = i_restore;
    assign w_shadow     = r_shadow;
    assign o_shadow_out = r_shadow;

    // Shadow captures the pre-edge data value, so save+restore swaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= RESET_VAL;
        end else if (i_save) begin
            r_shadow <= r_data;
        end
    end
`else
    assign w_restore = 1'b0;
    assign w_shadow  = '0;
`endif

    // Next data/carry: load > restore > inc > hold; carry only on a real wrap.
    always_comb begin
        w_data_next  = r_data;
        w_carry_next = 1'b0;
        if (w_any_load) begin
            w_data_next = w_sel_chain[0];
        end else if (w_restore) begin
            w_data_next = w_shadow;
        end else if (i_inc) begin
            w_data_next  = r_data + WIDTH'(1);
            w_carry_next = (r_data == '1);
        end
    end

    // Next conflict state: an event on the same edge as a clear wins.
    always_comb begin
        w_conflict_next     = r_conflict;
        w_conflict_cnt_next = r_conflict_cnt;
        if (w_event) begin
            w_conflict_next = 1'b1;
            if (i_clr_conflict) begin
                w_conflict_cnt_next = CNT_W'(1);
            end else if (r_conflict_cnt != CNT_MAX) begin
                w_conflict_cnt_next = r_conflict_cnt + CNT_W'(1);
            end
        end else if (i_clr_conflict) begin
            w_conflict_next     = 1'b0;
            w_conflict_cnt_next = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data         <= RESET_VAL;
            r_carry        <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_data         <= w_data_next;
            r_carry        <= w_carry_next;
            r_conflict     <= w_conflict_next;
            r_conflict_cnt <= w_conflict_cnt_next;
        end
    end

    assign o_data_out     = r_data;
    assign o_carry_out    = r_carry;
    assign o_conflict     = r_conflict;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule
